serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial N-bit unsigned subtractor: computes A - B one bit per clock, LSB first.
//   Each bit is one full-subtractor step: two cascaded half-subtractor stages plus a
//   registered borrow-chain flip-flop.
//   Sits downstream of the 1-bit half-subtractor stage and consumes its Diff/Borrow terms.
//   Trades WIDTH cycles of latency for one bit-slice of arithmetic.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range 1..32
// PORTS
//   clk     in   1      system clock; all state updates on rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request; sampled only when busy=0
//   A       in   WIDTH  minuend; sampled on the accepting edge only
//   B       in   WIDTH  subtrahend; sampled on the accepting edge only
//   busy    out  1      1 while a subtraction is in progress
//   done    out  1      one-cycle pulse; Diff/Borrow valid from this cycle
//   Diff    out  WIDTH  registered result (A - B) mod 2^WIDTH
//   Borrow  out  1      registered final borrow out; 1 iff A < B (unsigned)
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous, takes effect immediately):
//   - state=IDLE; busy=0, done=0, Diff=0, Borrow=0.
//   - Internal shift registers, borrow FF and bit counter cleared.
//   - Any subtraction in progress is abandoned; no done pulse is produced for it.
// - States: IDLE, SHIFT, DONE. Encoding is free.
// - IDLE: busy=0. start=1 at edge E0 is accepted:
//   - Latch A and B into shift registers; clear the borrow FF and the counter.
//   - Go to SHIFT. busy=1 from E0.
// - SHIFT: on each edge, process bit i = counter (i = 0..WIDTH-1):
//   - d_i = a_i ^ b_i ^ br
//   - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
//   - Shift d_i into the result register MSB-first so bit i lands at index i.
//   - Increment the counter.
//   - After the edge that processes bit WIDTH-1 (edge E0+WIDTH), go to DONE:
//     - Load Diff from the result register; load Borrow = br'.
//     - busy=0, done=1.
// - DONE: lasts exactly one cycle. done=0 on the next edge. busy=0, so start is
//   accepted here with the same rules as IDLE (back-to-back operation).
//   - If start is accepted in DONE: next state is SHIFT.
//   - If not: next state is IDLE.
// - Latency: done is high in the cycle after edge E0+WIDTH, i.e. WIDTH clocks after
//   the accepting edge. Throughput is one result per WIDTH+1 cycles with start held.
// - start, A and B are ignored while busy=1; operands may change freely then.
// - Diff and Borrow change only on the edge that raises done, or on reset.
//   Between results they hold the last value.
// - Unsigned arithmetic only. Diff wraps mod 2^WIDTH.
// - WIDTH=1 is legal and degenerates to a registered full subtractor with an
//   incoming borrow of 0.
// TESTING  (WIDTH=8 unless noted)
// - Reset check: rst_n low -> busy=0, done=0, Diff=0x00, Borrow=0.
// - Basic: A=0x5A, B=0x3C, start 1 cycle
//   -> done exactly 8 clocks after the accepting edge; Diff=0x1E, Borrow=0.
// - Wrap-around: A=0x00, B=0x01 -> Diff=0xFF, Borrow=1.
//   A=0xAA, B=0xAA -> Diff=0x00, Borrow=0.
//   A=0xFF, B=0x00 -> Diff=0xFF, Borrow=0.
// - Busy / back-to-back:
//   - Start 0x10-0x01; pulse start with 0x00-0x00 while busy=1 -> ignored, Diff=0x0F.
//   - Hold start=1 with A=0x03, B=0x05 through the done cycle -> second done 9 cycles
//     after the first; Diff=0xFE, Borrow=1.
// - Reset mid-operation: start 0x80-0x01, assert rst_n low after 4 clocks
//   -> immediate busy=0, Diff=0x00, Borrow=0; no done pulse after release.
//   A new start then completes normally.
// - Random: 1000 random A/B pairs at WIDTH=8 and WIDTH=1, compared against a
//   {Borrow,Diff} = {1'b0,A} - {1'b0,B} model.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module   : serial_subtractor_if
// Brief    : Request/result bundle between a client and the bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;

    modport master (
        output start, A, B,
        input  busy, done, Diff, Borrow
    );

    modport slave (
        input  start, A, B,
        output busy, done, Diff, Borrow
    );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned A - B, LSB first, one full-subtractor step per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             hs1_diff, hs1_borrow;
    logic             hs2_diff, hs2_borrow;
    logic             accept;
    logic [WIDTH-1:0] res_shift;

    // Two cascaded half subtractors: (a - b), then (that - borrow-in).
    assign hs1_diff   = a_q[0] ^ b_q[0];
    assign hs1_borrow = ~a_q[0] & b_q[0];
    assign hs2_diff   = hs1_diff ^ br_q;
    assign hs2_borrow = ~hs1_diff & br_q;

    // New bit enters at the MSB so that after WIDTH steps bit i sits at index i.
    generate
        if (WIDTH > 1) begin : g_res_wide
            assign res_shift = {hs2_diff, res_q[WIDTH-1:1]};
        end else begin : g_res_single
            assign res_shift = hs2_diff;
        end
    endgenerate

    assign accept = bus.start && (state_q != SHIFT);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = hs1_borrow | hs2_borrow;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d  = DONE;
                    diff_d   = res_shift;
                    borrow_d = hs1_borrow | hs2_borrow;
                end
            end
            IDLE, DONE: begin
                if (accept) begin
                    state_d = SHIFT;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.busy   = (state_q == SHIFT);
    assign bus.done   = (state_q == DONE);
    assign bus.Diff   = diff_q;
    assign bus.Borrow = borrow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(1)) if1 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one 8-bit request; lat = clocks from accepting edge to done (40 = timeout).
    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        if8.A     = a;
        if8.B     = b;
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (if8.done) break;
        end
    endtask

    task automatic run1(input logic a, input logic b, output int lat);
        @(negedge clk);
        if1.A     = a;
        if1.B     = b;
        if1.start = 1'b1;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (if1.done) break;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        if8.start = 1'b0; if8.A = '0; if8.B = '0;
        if1.start = 1'b0; if1.A = '0; if1.B = '0;
        #1;
        n_checks++; if (if8.busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b want 0", if8.busy); end
        n_checks++; if (if8.done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %b want 0", if8.done); end
        n_checks++; if (if8.Diff !== 8'h00)  begin n_fail++; $display("FAIL reset_diff got %h want 00", if8.Diff); end
        n_checks++; if (if8.Borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow got %b want 0", if8.Borrow); end
        n_checks++; if (if1.busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy_w1 got %b want 0", if1.busy); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        @(negedge clk);
        if8.A = 8'h5A; if8.B = 8'h3C; if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        n_checks++; if (if8.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_accept got %b want 1", if8.busy); end
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (if8.done) break;
        end
        n_checks++; if (lat !== 8)          begin n_fail++; $display("FAIL basic_latency got %0d want 8", lat); end
        n_checks++; if (if8.Diff !== 8'h1E) begin n_fail++; $display("FAIL basic_diff got %h want 1e", if8.Diff); end
        n_checks++; if (if8.Borrow !== 1'b0) begin n_fail++; $display("FAIL basic_borrow got %b want 0", if8.Borrow); end
        n_checks++; if (if8.busy !== 1'b0)  begin n_fail++; $display("FAIL basic_busy_in_done got %b want 0", if8.busy); end
        @(posedge clk);
        #1;
        n_checks++; if (if8.done !== 1'b0)  begin n_fail++; $display("FAIL basic_done_one_cycle got %b want 0", if8.done); end
        n_checks++; if (if8.Diff !== 8'h1E) begin n_fail++; $display("FAIL basic_diff_hold got %h want 1e", if8.Diff); end
    endtask

    task automatic test_wrap();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] vd [3];
        logic       vbr[3];
        int lat;
        va[0] = 8'h00; vb[0] = 8'h01; vd[0] = 8'hFF; vbr[0] = 1'b1;
        va[1] = 8'hAA; vb[1] = 8'hAA; vd[1] = 8'h00; vbr[1] = 1'b0;
        va[2] = 8'hFF; vb[2] = 8'h00; vd[2] = 8'hFF; vbr[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run8(va[i], vb[i], lat);
            n_checks++;
            if (lat !== 8 || if8.Diff !== vd[i] || if8.Borrow !== vbr[i]) begin
                n_fail++;
                $display("FAIL wrap_%0d got lat=%0d diff=%h borrow=%b want lat=8 diff=%h borrow=%b",
                         i, lat, if8.Diff, if8.Borrow, vd[i], vbr[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        if8.A = 8'h10; if8.B = 8'h01; if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if8.A = 8'h00; if8.B = 8'h00; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        lat = 3;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (if8.done) break;
        end
        n_checks++; if (lat !== 8)           begin n_fail++; $display("FAIL busy_ignore_latency got %0d want 8", lat); end
        n_checks++; if (if8.Diff !== 8'h0F)  begin n_fail++; $display("FAIL busy_ignore_diff got %h want 0f", if8.Diff); end
        n_checks++; if (if8.Borrow !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_borrow got %b want 0", if8.Borrow); end
        @(posedge clk);
        #1;
        n_checks++; if (if8.busy !== 1'b0)   begin n_fail++; $display("FAIL busy_ignore_idle got %b want 0", if8.busy); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        @(negedge clk);
        if8.A = 8'h20; if8.B = 8'h01; if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.A = 8'h03; if8.B = 8'h05;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (if8.done) break;
        end
        n_checks++; if (lat !== 8 || if8.Diff !== 8'h1F) begin
            n_fail++; $display("FAIL b2b_first got lat=%0d diff=%h want lat=8 diff=1f", lat, if8.Diff);
        end
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        gap = 1;
        n_checks++; if (if8.busy !== 1'b1)  begin n_fail++; $display("FAIL b2b_restart_busy got %b want 1", if8.busy); end
        n_checks++; if (if8.Diff !== 8'h1F) begin n_fail++; $display("FAIL b2b_diff_hold got %h want 1f", if8.Diff); end
        while (gap < 40) begin
            @(posedge clk);
            #1;
            gap++;
            if (if8.done) break;
        end
        n_checks++; if (gap !== 9)           begin n_fail++; $display("FAIL b2b_gap got %0d want 9", gap); end
        n_checks++; if (if8.Diff !== 8'hFE)  begin n_fail++; $display("FAIL b2b_diff got %h want fe", if8.Diff); end
        n_checks++; if (if8.Borrow !== 1'b1) begin n_fail++; $display("FAIL b2b_borrow got %b want 1", if8.Borrow); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        @(negedge clk);
        if8.A = 8'h80; if8.B = 8'h01; if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (if8.busy !== 1'b0)   begin n_fail++; $display("FAIL midreset_busy got %b want 0", if8.busy); end
        n_checks++; if (if8.Diff !== 8'h00)  begin n_fail++; $display("FAIL midreset_diff got %h want 00", if8.Diff); end
        n_checks++; if (if8.Borrow !== 1'b0) begin n_fail++; $display("FAIL midreset_borrow got %b want 0", if8.Borrow); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (if8.done || if8.busy) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_done got %0d active cycles want 0", seen); end
        run8(8'h80, 8'h01, lat);
        n_checks++; if (lat !== 8 || if8.Diff !== 8'h7F || if8.Borrow !== 1'b0) begin
            n_fail++; $display("FAIL midreset_recover got lat=%0d diff=%h borrow=%b want lat=8 diff=7f borrow=0",
                               lat, if8.Diff, if8.Borrow);
        end
    endtask

    task automatic test_random8();
        logic [7:0] a, b;
        logic [8:0] exp;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            exp = {1'b0, a} - {1'b0, b};
            run8(a, b, lat);
            n_checks++;
            if (lat !== 8 || {if8.Borrow, if8.Diff} !== exp) begin
                n_fail++;
                $display("FAIL rand8 a=%h b=%h got lat=%0d {borrow,diff}=%h want lat=8 %h",
                         a, b, lat, {if8.Borrow, if8.Diff}, exp);
            end
        end
    endtask

    task automatic test_random1();
        logic       a, b;
        logic [1:0] exp;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a   = 1'($urandom);
            b   = 1'($urandom);
            exp = {1'b0, a} - {1'b0, b};
            run1(a, b, lat);
            n_checks++;
            if (lat !== 1 || {if1.Borrow, if1.Diff} !== exp) begin
                n_fail++;
                $display("FAIL rand1 a=%b b=%b got lat=%0d {borrow,diff}=%b want lat=1 %b",
                         a, b, lat, {if1.Borrow, if1.Diff}, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random8();
        test_random1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
